// File: rtl/stepper_driver.sv
`default_nettype none
// stepper_driver: 4-coil stepper phase sequencer with full/half-step modes, a
// programmable step period and a step-count budget.  Rev 1.0
module stepper_driver #(
  parameter int DIV_W     = 16,
  parameter int CNT_W     = 16,
  parameter int IDLE_HOLD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic             dir,
  input  logic             half_step,
  input  logic [DIV_W-1:0] period,
  input  logic [CNT_W-1:0] steps,
  output logic [3:0]       coils,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             half_q, half_d;
  logic             done_q, done_d;
  logic             energised_q, energised_d;
  logic [3:0]       coils_q, coils_d;
  logic [2:0]       w_inc;

  function automatic logic [3:0] phase(input logic [2:0] i);
    case (i)
      3'd0:    phase = 4'b0001;
      3'd1:    phase = 4'b0011;
      3'd2:    phase = 4'b0010;
      3'd3:    phase = 4'b0110;
      3'd4:    phase = 4'b0100;
      3'd5:    phase = 4'b1100;
      3'd6:    phase = 4'b1000;
      default: phase = 4'b1001;
    endcase
  endfunction

  // Full-step lands on odd indices (two coils on); an even index first aligns by one.
  assign w_inc = (half_q || !idx_q[0]) ? 3'd1 : 3'd2;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    div_d       = div_q;
    per_d       = per_q;
    rem_d       = rem_q;
    dir_d       = dir_q;
    half_d      = half_q;
    energised_d = energised_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && start) begin
          if (steps != '0) begin
            state_d = RUN;
            dir_d   = dir;
            half_d  = half_step;
            per_d   = (period == '0) ? DIV_ONE : period;
            rem_d   = steps;
            div_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        if (!enable) begin
          state_d = IDLE;
          rem_d   = '0;
          div_d   = '0;
        end else if (div_q == per_q - DIV_ONE) begin
          div_d = '0;
          rem_d = rem_q - CNT_ONE;
          // The first step after reset energises the current phase instead of moving.
          if (!energised_q) energised_d = 1'b1;
          else              idx_d = dir_q ? (idx_q + w_inc) : (idx_q - w_inc);
          if (rem_q == CNT_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
    endcase
    coils_d = '0;
    if (enable && energised_d && ((state_d == RUN) || (IDLE_HOLD != 0)))
      coils_d = phase(idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      div_q       <= '0;
      per_q       <= DIV_ONE;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      half_q      <= 1'b0;
      done_q      <= 1'b0;
      energised_q <= 1'b0;
      coils_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      div_q       <= div_d;
      per_q       <= per_d;
      rem_q       <= rem_d;
      dir_q       <= dir_d;
      half_q      <= half_d;
      done_q      <= done_d;
      energised_q <= energised_d;
      coils_q     <= coils_d;
    end
  end

  assign coils     = coils_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign remaining = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_stepper_driver.sv
`default_nettype none
// Directed bench for stepper_driver; a second instance runs with IDLE_HOLD=0.
module tb_stepper_driver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, start = 1'b0, dir = 1'b0, half_step = 1'b0;
  logic [15:0] period = '0, steps = '0;
  logic [3:0]  coils, coils0;
  logic        busy, done, busy0, done0;
  logic [15:0] remaining, remaining0;

  int checks = 0, errors = 0, busy_cnt = 0, done_cnt = 0;
  logic [3:0] exp1 [9] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100,
                           4'b1100, 4'b1000, 4'b1001, 4'b0001};
  logic [3:0] prev;

  stepper_driver #(.DIV_W(16), .CNT_W(16), .IDLE_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .dir(dir),
    .half_step(half_step), .period(period), .steps(steps),
    .coils(coils), .busy(busy), .done(done), .remaining(remaining));

  stepper_driver #(.DIV_W(16), .CNT_W(16), .IDLE_HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .dir(dir),
    .half_step(half_step), .period(period), .steps(steps),
    .coils(coils0), .busy(busy0), .done(done0), .remaining(remaining0));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic d, input logic h, input logic [15:0] p, input logic [15:0] s);
    dir = d; half_step = h; period = p; steps = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_coils", 32'(coils), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_rem", 32'(remaining), 32'h0);

    // Half-step forward, period 3, 9 steps; start taken on first edge after reset
    rst_n = 1'b1; enable = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    go(1'b1, 1'b1, 16'd3, 16'd9);
    chk("s1_busy0", 32'(busy), 32'h1);
    chk("s1_rem0", 32'(remaining), 32'd9);
    chk("s1_coils0", 32'(coils), 32'h0);
    prev = 4'b0000;
    for (int k = 0; k < 9; k++) begin
      tick(); tick();
      chk("s1_hold", 32'(coils), 32'(prev));
      tick();
      chk("s1_coils", 32'(coils), 32'(exp1[k]));
      chk("s1_rem", 32'(remaining), 32'(8 - k));
      prev = exp1[k];
    end
    chk("s1_done", 32'(done), 32'h1);
    chk("s1_busy_end", 32'(busy), 32'h0);
    chk("s1_nohold_coils", 32'(coils0), 32'h0);
    tick();
    chk("s1_done_pulse", 32'(done), 32'h0);
    chk("s1_busy_cnt", 32'(busy_cnt), 32'd27);
    chk("s1_done_cnt", 32'(done_cnt), 32'd1);
    chk("s1_hold_coils", 32'(coils), 32'b0001);

    // Full-step reverse from index 0, one step per cycle
    go(1'b0, 1'b0, 16'd1, 16'd4);
    chk("s2_start_coils0", 32'(coils0), 32'b0001);
    tick(); chk("s2_c1", 32'(coils), 32'b1001); chk("s2_r1", 32'(remaining), 32'd3);
    chk("s2_nohold_run", 32'(coils0), 32'b1001);
    tick(); chk("s2_c2", 32'(coils), 32'b1100); chk("s2_r2", 32'(remaining), 32'd2);
    tick(); chk("s2_c3", 32'(coils), 32'b0110); chk("s2_r3", 32'(remaining), 32'd1);
    tick(); chk("s2_c4", 32'(coils), 32'b0011); chk("s2_r4", 32'(remaining), 32'd0);
    chk("s2_done", 32'(done), 32'h1);
    chk("s2_nohold_end", 32'(coils0), 32'h0);

    // period=0 acts as period=1 (index 1 -> 2 -> 3)
    go(1'b1, 1'b1, 16'd0, 16'd2);
    tick(); chk("s3_c1", 32'(coils), 32'b0010);
    tick(); chk("s3_c2", 32'(coils), 32'b0110); chk("s3_done", 32'(done), 32'h1);

    // steps=0: done next cycle, never busy, coils unchanged
    tick();
    go(1'b1, 1'b1, 16'd1, 16'd0);
    chk("s4_done", 32'(done), 32'h1);
    chk("s4_busy", 32'(busy), 32'h0);
    chk("s4_coils", 32'(coils), 32'b0110);
    tick();
    chk("s4_done_off", 32'(done), 32'h0);

    // Enable dropped after 2 of 5 steps, then resume from held index
    done_cnt = 0;
    go(1'b1, 1'b1, 16'd2, 16'd5);
    tick(); tick(); chk("s5_c1", 32'(coils), 32'b0100);
    tick(); tick(); chk("s5_c2", 32'(coils), 32'b1100); chk("s5_r2", 32'(remaining), 32'd3);
    enable = 1'b0;
    tick();
    chk("s5_coils_off", 32'(coils), 32'h0);
    chk("s5_busy_off", 32'(busy), 32'h0);
    chk("s5_rem_off", 32'(remaining), 32'h0);
    chk("s5_no_done", 32'(done_cnt), 32'd0);
    enable = 1'b1;
    go(1'b1, 1'b1, 16'd1, 16'd1);
    chk("s5_restart_coils", 32'(coils), 32'b1100);
    tick(); chk("s5_resume", 32'(coils), 32'b1000);

    // Input changes and start during RUN are ignored; async reset mid-move
    tick();
    go(1'b1, 1'b1, 16'd2, 16'd3);
    tick();
    start = 1'b1; steps = 16'd7; dir = 1'b0; half_step = 1'b0; period = 16'd1;
    tick();
    start = 1'b0;
    chk("s6_rem", 32'(remaining), 32'd2);
    chk("s6_c1", 32'(coils), 32'b1001);
    tick(); tick();
    chk("s6_c2", 32'(coils), 32'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_arst_busy", 32'(busy), 32'h0);
    chk("s6_arst_coils", 32'(coils), 32'h0);
    chk("s6_arst_rem", 32'(remaining), 32'h0);
    tick();
    chk("s6_arst_done", 32'(done), 32'h0);

    // After reset the first step energises index 0 without moving
    rst_n = 1'b1;
    go(1'b1, 1'b1, 16'd1, 16'd1);
    chk("s7_coils0", 32'(coils), 32'h0);
    chk("s7_busy", 32'(busy), 32'h1);
    tick();
    chk("s7_coils", 32'(coils), 32'b0001);
    chk("s7_done", 32'(done), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
